usart_tx_arbiter: RTL and testbench

Shares the single USART transmitter between several message producers (command-response path, NACK generator, streaming sample path). Each producer offers a complete frame through a valid/ready handshake. The arbiter picks one in round-robin order, drives the transmitter's valid/ready write port, and reports completion or timeout back to the winning producer. It sits between the managers and the USART TX writer port.

---
 rtl/usart_tx_arbiter_pkg.sv | 15 +
 rtl/usart_rr_picker.sv | 30 +++
 rtl/usart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_tx_arbiter_pkg.sv
// rtl/usart_tx_arbiter_pkg.sv - shared types and helpers for the USART transmit arbiter
package usart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } tx_arb_state_t;

  // One spare bit keeps the saturated count distinguishable from the abort threshold.
  function automatic int arb_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles) + 1;
  endfunction

endpackage

// File: rtl/usart_rr_picker.sv
// rtl/usart_rr_picker.sv - combinational round-robin search over a request vector
module usart_rr_picker
  import usart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               found,
  output logic [IDW-1:0]     index
);

  logic [IDW-1:0] pos;

  // Offset 1 first and offset NUM_REQ last, so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// rtl/usart_tx_arbiter.sv - round-robin arbiter sharing one USART transmitter among producers
module usart_tx_arbiter
  import usart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int MSG_LENGTH     = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rsnt,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*MSG_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [MSG_LENGTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int              IDW       = $clog2(NUM_REQ);
  localparam int              CW        = arb_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0]  LAST_INIT = IDW'(NUM_REQ - 1);

  tx_arb_state_t         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [IDW-1:0]        grant_id_q, grant_id_d;
  logic [MSG_LENGTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    req_done_q, req_done_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;

  usart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    req_ready_d   = '0;
    req_done_d    = '0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found && tx_ready) begin
          state_d    = LOAD;
          cnt_d      = '0;
          grant_id_d = pick_idx;
          tx_valid_d = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == pick_idx) begin
              req_ready_d[i] = 1'b1;
              tx_data_d      = req_data[i*MSG_LENGTH +: MSG_LENGTH];
            end
          end
        end
      end
      LOAD: begin
        if (!tx_ready) begin
          state_d    = BUSY;
          cnt_d      = '0;
          tx_valid_d = 1'b0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d       = IDLE;
          tx_valid_d    = 1'b0;
          timeout_err_d = 1'b1;
          last_grant_d  = grant_id_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BUSY: begin
        if (tx_ready) begin
          state_d                = IDLE;
          req_done_d[grant_id_q] = 1'b1;
          last_grant_d           = grant_id_q;
        end else if (cnt_q >= CNT_LAST) begin
          // Transmitter never came back: release the port, no completion reported.
          state_d       = IDLE;
          tx_valid_d    = 1'b0;
          timeout_err_d = 1'b1;
          last_grant_d  = grant_id_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsnt) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= LAST_INIT;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      req_ready_q   <= '0;
      req_done_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      req_ready_q   <= req_ready_d;
      req_done_q    <= req_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb/tb_usart_tx_arbiter.sv - directed self-checking bench for usart_tx_arbiter
module tb_usart_tx_arbiter;

  localparam int NUM_REQ        = 3;
  localparam int MSG_LENGTH     = 48;
  localparam int TIMEOUT_CYCLES = 16;

  logic                          clk = 1'b0;
  logic                          rsnt;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*MSG_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_done;
  logic [MSG_LENGTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [1:0]                    grant_id;
  logic                          busy;
  logic                          timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MSG_LENGTH     (MSG_LENGTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rsnt        (rsnt),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rsnt      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    step();
    step();
    checks++;
    if ({req_ready, req_done, tx_valid, busy, timeout_err, grant_id} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b done=%b valid=%b busy=%b tmo=%b gid=%0d, required all 0",
               req_ready, req_done, tx_valid, busy, timeout_err, grant_id);
    end
    checks++;
    if (tx_data !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", tx_data);
    end
    rsnt = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b ready=%b, required 0/000", busy, req_ready);
    end
  endtask

  task automatic test_single_frame();
    req_valid = 3'b001;
    req_data  = {48'h0, 48'h0, 48'hA5A5_0000_0001};
    tx_ready  = 1'b1;
    step();
    checks++;
    if (req_ready !== 3'b001 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got ready=%b valid=%b, required 001/1", req_ready, tx_valid);
    end
    checks++;
    if (tx_data !== 48'hA5A5_0000_0001) begin
      errors++;
      $display("FAIL single_data: got %h, required a5a500000001", tx_data);
    end
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gid: got gid=%0d busy=%b, required 0/1", grant_id, busy);
    end
    req_valid = 3'b000;
    tx_ready  = 1'b0;
    step();
    checks++;
    if (tx_valid !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL single_start: got valid=%b ready=%b, required 0/000", tx_valid, req_ready);
    end
    for (int c = 0; c < 9; c++) begin
      step();
      checks++;
      if (req_done !== 3'b000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_busy cycle %0d: got done=%b busy=%b, required 000/1", c, req_done, busy);
      end
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if (req_done !== 3'b001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done=%b busy=%b, required 001/0", req_done, busy);
    end
    step();
    checks++;
    if (req_done !== 3'b000) begin
      errors++;
      $display("FAIL single_done_pulse: got %b, required 000", req_done);
    end
  endtask

  task automatic test_round_robin();
    logic [47:0] rr_data [3];
    logic [2:0]  onehot;
    int          n;
    int          expid;
    rr_data[0] = 48'h0A0A_7777_8888;
    rr_data[1] = 48'h1111_5555_6666;
    rr_data[2] = 48'h2222_3333_4444;
    rsnt = 1'b1;
    step();
    rsnt      = 1'b0;
    tx_ready  = 1'b1;
    req_valid = 3'b111;
    req_data  = {rr_data[2], rr_data[1], rr_data[0]};
    for (int f = 0; f < 6; f++) begin
      expid  = f % 3;
      onehot = 3'b001 << expid;
      n = 0;
      while (tx_valid !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      checks++;
      if (tx_valid !== 1'b1 || n < 1) begin
        errors++;
        $display("FAIL rr_wait frame %0d: got valid=%b after %0d cycles, required 1 after >=1", f, tx_valid, n);
      end
      checks++;
      if (grant_id !== 2'(expid) || req_ready !== onehot) begin
        errors++;
        $display("FAIL rr_grant frame %0d: got gid=%0d ready=%b, required %0d/%b", f, grant_id, req_ready, expid, onehot);
      end
      checks++;
      if (tx_data !== rr_data[expid]) begin
        errors++;
        $display("FAIL rr_data frame %0d: got %h, required %h", f, tx_data, rr_data[expid]);
      end
      tx_ready = 1'b0;
      repeat (5) step();
      tx_ready = 1'b1;
      step();
      checks++;
      if (req_done !== onehot) begin
        errors++;
        $display("FAIL rr_done frame %0d: got %b, required %b", f, req_done, onehot);
      end
    end
  endtask

  task automatic test_single_requester();
    int n;
    req_valid = 3'b100;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (tx_valid !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      checks++;
      if (grant_id !== 2'd2 || req_ready !== 3'b100 || tx_valid !== 1'b1) begin
        errors++;
        $display("FAIL solo_grant frame %0d: got gid=%0d ready=%b valid=%b, required 2/100/1", f, grant_id, req_ready, tx_valid);
      end
      tx_ready = 1'b0;
      repeat (3) step();
      tx_ready = 1'b1;
      step();
      checks++;
      if (req_done !== 3'b100 || busy !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL solo_done frame %0d: got done=%b busy=%b valid=%b, required 100/0/0", f, req_done, busy, tx_valid);
      end
    end
  endtask

  task automatic test_timeout();
    req_valid = 3'b001;
    step();
    checks++;
    if (grant_id !== 2'd0 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_grant: got gid=%0d valid=%b, required 0/1", grant_id, tx_valid);
    end
    req_valid = 3'b000;
    for (int c = 1; c < TIMEOUT_CYCLES; c++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold cycle %0d: got valid=%b tmo=%b, required 1/0", c, tx_valid, timeout_err);
      end
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: got tmo=%b valid=%b, required 1/0", timeout_err, tx_valid);
    end
    checks++;
    if (req_done !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_nodone: got done=%b busy=%b, required 000/0", req_done, busy);
    end
    req_valid = 3'b011;
    step();
    checks++;
    if (timeout_err !== 1'b0 || grant_id !== 2'd1 || req_ready !== 3'b010) begin
      errors++;
      $display("FAIL tmo_next: got tmo=%b gid=%0d ready=%b, required 0/1/010", timeout_err, grant_id, req_ready);
    end
    req_valid = 3'b000;
    tx_ready  = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    checks++;
    if (req_done !== 3'b010) begin
      errors++;
      $display("FAIL tmo_next_done: got %b, required 010", req_done);
    end
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 3'b100;
    step();
    checks++;
    if (grant_id !== 2'd2) begin
      errors++;
      $display("FAIL rstb_grant: got gid=%0d, required 2", grant_id);
    end
    req_valid = 3'b000;
    tx_ready  = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstb_busy: got %b, required 1", busy);
    end
    rsnt = 1'b1;
    step();
    checks++;
    if ({req_ready, req_done, tx_valid, busy, timeout_err, grant_id} !== 11'd0 || tx_data !== 48'h0) begin
      errors++;
      $display("FAIL rstb_clear: got ready=%b done=%b valid=%b busy=%b tmo=%b gid=%0d data=%h, required all 0",
               req_ready, req_done, tx_valid, busy, timeout_err, grant_id, tx_data);
    end
    rsnt      = 1'b0;
    req_valid = 3'b010;
    tx_ready  = 1'b1;
    step();
    checks++;
    if (grant_id !== 2'd1 || req_ready !== 3'b010 || req_done !== 3'b000) begin
      errors++;
      $display("FAIL rstb_regrant: got gid=%0d ready=%b done=%b, required 1/010/000", grant_id, req_ready, req_done);
    end
    req_valid = 3'b000;
    tx_ready  = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    checks++;
    if (req_done !== 3'b010) begin
      errors++;
      $display("FAIL rstb_done: got %b, required 010", req_done);
    end
  endtask

  task automatic test_tx_ready_low_idle();
    req_valid = 3'b010;
    tx_ready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (req_ready !== 3'b000 || tx_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold_idle cycle %0d: got ready=%b valid=%b busy=%b, required 000/0/0", c, req_ready, tx_valid, busy);
      end
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if (req_ready !== 3'b010 || grant_id !== 2'd1 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_grant: got ready=%b gid=%0d valid=%b, required 010/1/1", req_ready, grant_id, tx_valid);
    end
    req_valid = 3'b000;
    tx_ready  = 1'b0;
    step();
    tx_ready = 1'b1;
    step();
    checks++;
    if (req_done !== 3'b010) begin
      errors++;
      $display("FAIL hold_done: got %b, required 010", req_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_single_requester();
    test_timeout();
    test_reset_mid_busy();
    test_tx_ready_low_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
